// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for the boot loader.
// The master is the byte source / memory side; the slave is the loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction
// memory, checks a trailing XOR checksum and holds the core in reset until done.
module imem_loader #(
  parameter int unsigned InstLength = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_restart,
  imem_loader_if.slave bus,
  output logic         o_core_rst_n,
  output logic         o_load_done,
  output logic         o_load_error
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_LEN_CHK,
    S_PAYLOAD,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_lane;
  logic [23:0] r_asm;
  logic [7:0]  r_xor;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_core_rst_n;
  logic        r_done;
  logic        r_error;

  logic        w_ready;
  logic        w_accept;
  logic        w_last_word;

  // Ready is gated by the raw reset so it reads 0 while rst_n is held low.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_CSUM: w_ready = i_rst_n;
      default:                               w_ready = 1'b0;
    endcase
  end

  assign w_accept    = bus.byte_valid && w_ready;
  assign w_last_word = (r_word_cnt + 16'd1) == r_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_HDR_LO;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_lane       <= '0;
      r_asm        <= '0;
      r_xor        <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_restart) begin
        // Restart wins over a same-cycle accept: the byte and its write are dropped.
        r_state      <= S_HDR_LO;
        r_len        <= '0;
        r_word_cnt   <= '0;
        r_lane       <= '0;
        r_xor        <= '0;
        r_core_rst_n <= 1'b0;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
      end else begin
        case (r_state)
          S_HDR_LO: begin
            if (w_accept) begin
              r_len[7:0] <= bus.byte_data;
              r_state    <= S_HDR_HI;
            end
          end
          S_HDR_HI: begin
            if (w_accept) begin
              r_len[15:8] <= bus.byte_data;
              r_state     <= S_LEN_CHK;
            end
          end
          S_LEN_CHK: begin
            if (r_len == 16'd0 || 32'(r_len) > InstLength) begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else begin
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (w_accept) begin
              r_xor  <= r_xor ^ bus.byte_data;
              r_lane <= r_lane + 2'd1;
              r_asm  <= {bus.byte_data, r_asm[23:8]};
              if (r_lane == 2'd3) begin
                r_we       <= 1'b1;
                r_waddr    <= 32'(r_word_cnt);
                r_wdata    <= {bus.byte_data, r_asm};
                r_word_cnt <= r_word_cnt + 16'd1;
                if (w_last_word) r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (w_accept) begin
              if (bus.byte_data == r_xor) begin
                r_done       <= 1'b1;
                r_core_rst_n <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_error <= 1'b1;
                r_state <= S_ERROR;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign o_core_rst_n   = r_core_rst_n;
  assign o_load_done    = r_done;
  assign o_load_error   = r_error;

endmodule
